// File: rtl/diag_pkg.sv
`default_nettype none
// ============================================================================
// Module : diag_pkg
// Brief  : Shared types and row-entry layout for the diagonal fetch controller.
// Rev    : 1.0
// ============================================================================
package diag_pkg;

    localparam int ROW_W      = 11;
    localparam int ROW_DATA_W = 256;
    localparam int ENTRY_W    = 16;
    localparam int ENTRIES    = ROW_DATA_W / ENTRY_W;

    // Row entry layout: {flag[2:0], value[2:0], column[9:0]}
    localparam int FLAG_MSB = 15;
    localparam int FLAG_LSB = 13;
    localparam int VAL_MSB  = 12;
    localparam int VAL_LSB  = 10;
    localparam int COL_MSB  = 9;
    localparam int COL_LSB  = 0;

    localparam logic [2:0] FLAG_VALID = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_FIN     = 3'd6
    } state_t;

    typedef enum logic {
        CH_X = 1'b0,
        CH_Y = 1'b1
    } chan_t;

    function automatic logic entry_hits(input logic [ENTRY_W-1:0] entry,
                                        input logic [15:0]        col);
        return (entry[FLAG_MSB:FLAG_LSB] == FLAG_VALID) &&
               (entry[COL_MSB:COL_LSB] == col[COL_MSB:COL_LSB]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter, one-hot grant, pointer moves on accept.
// Rev    : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    input  logic       restart_i,
    output logic [1:0] gnt_o
);

    // ptr_q = 0 favours requester 0 when both are asking
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (restart_i) begin
            ptr_d = 1'b0;
        end else if (accept_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/diag_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : diag_fetch_ctrl
// Brief  : Fetches rows for X/Y diagonal searches and feeds the update unit.
// Rev    : 1.0
// ============================================================================
module diag_fetch_ctrl
    import diag_pkg::*;
#(
    parameter int NUM_ROWS = 1024,
    parameter int ROW_W    = diag_pkg::ROW_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           X,
    input  logic [15:0]           Y,
    output logic                  mem_req,
    output logic [ROW_W-1:0]      mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [ROW_DATA_W-1:0] mem_rdata,
    output logic [ROW_DATA_W-1:0] NewRowX,
    output logic [ROW_DATA_W-1:0] NewRowY,
    output logic [ROW_W-1:0]      Row_noX,
    output logic [ROW_W-1:0]      Row_noY,
    output logic                  EnableChange,
    input  logic                  DiagonalDoneX,
    input  logic                  DiagonalDoneY,
    output logic                  busy,
    output logic                  done,
    output logic                  found_x,
    output logic                  found_y,
    output logic [15:0]           TargetX,
    output logic [15:0]           TargetY
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_t                  state_q, state_d;
    logic [15:0]             x_q, y_q;
    logic [ROW_W-1:0]        rx_q, ry_q;
    logic [1:0]              active_q;
    logic                    found_x_q, found_y_q;
    chan_t                   sel_q;
    logic [ROW_DATA_W-1:0]   rdata_q;
    logic [ROW_W-1:0]        row_nox_q, row_noy_q;

    logic [1:0]              gnt;
    logic                    accept;
    logic                    restart;
    logic [ROW_W-1:0]        issue_cnt;
    logic [ROW_W-1:0]        served_cnt;
    logic                    served_hit;
    logic                    served_last;
    logic [1:0]              retire_mask;
    logic [1:0]              active_after;

    rr_arb2 u_arb (
        .clk_i     (clock),
        .rst_i     (reset),
        .req_i     (active_q),
        .accept_i  (accept),
        .restart_i (restart),
        .gnt_o     (gnt)
    );

    assign issue_cnt    = gnt[0] ? rx_q : ry_q;
    assign served_cnt   = (sel_q == CH_Y) ? ry_q : rx_q;
    // Only the served channel's flag counts; the other one is ignored here
    assign served_hit   = (sel_q == CH_Y) ? DiagonalDoneY : DiagonalDoneX;
    assign served_last  = (served_cnt == LAST_ROW);
    assign retire_mask  = (served_hit || served_last)
                          ? ((sel_q == CH_Y) ? 2'b10 : 2'b01) : 2'b00;
    assign active_after = active_q & ~retire_mask;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    restart = 1'b1;
                end
            end
            ST_CLEAR:   state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                    accept  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: state_d = ST_CHECK;
            ST_CHECK:   state_d = (active_after == 2'b00) ? ST_FIN : ST_ISSUE;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            active_q  <= 2'b00;
            found_x_q <= 1'b0;
            found_y_q <= 1'b0;
            sel_q     <= CH_X;
            rdata_q   <= '0;
            row_nox_q <= '0;
            row_noy_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q       <= X;
                        y_q       <= Y;
                        rx_q      <= '0;
                        ry_q      <= '0;
                        active_q  <= 2'b11;
                        found_x_q <= 1'b0;
                        found_y_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        sel_q <= gnt[1] ? CH_Y : CH_X;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        if (sel_q == CH_Y) begin
                            row_noy_q <= ry_q;
                        end else begin
                            row_nox_q <= rx_q;
                        end
                    end
                end
                ST_CHECK: begin
                    active_q <= active_after;
                    if (served_hit) begin
                        if (sel_q == CH_Y) begin
                            found_y_q <= 1'b1;
                        end else begin
                            found_x_q <= 1'b1;
                        end
                    end else if (!served_last) begin
                        if (sel_q == CH_Y) begin
                            ry_q <= ry_q + 1'b1;
                        end else begin
                            rx_q <= rx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Row data only leaves the block during PRESENT; an all-zero row never matches
    assign NewRowX      = ((state_q == ST_PRESENT) && (sel_q == CH_X)) ? rdata_q : '0;
    assign NewRowY      = ((state_q == ST_PRESENT) && (sel_q == CH_Y)) ? rdata_q : '0;
    assign Row_noX      = row_nox_q;
    assign Row_noY      = row_noy_q;
    assign mem_req      = (state_q == ST_ISSUE);
    assign mem_addr     = (state_q == ST_ISSUE) ? issue_cnt : '0;
    assign EnableChange = (state_q == ST_CLEAR);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);
    assign found_x      = found_x_q;
    assign found_y      = found_y_q;
    assign TargetX      = x_q;
    assign TargetY      = y_q;

endmodule
`default_nettype wire

// File: tb/tb_diag_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_diag_fetch_ctrl
// Brief  : Scoreboard bench with memory responder and update-unit model.
// Rev    : 1.0
// ============================================================================
module tb_diag_fetch_ctrl;
    import diag_pkg::*;

    localparam int N  = 4;
    localparam int RW = 11;

    logic            clock = 1'b0;
    logic            reset, start;
    logic [15:0]     X, Y;
    logic            mem_req, mem_gnt, mem_rvalid;
    logic [RW-1:0]   mem_addr;
    logic [255:0]    mem_rdata, NewRowX, NewRowY;
    logic [RW-1:0]   Row_noX, Row_noY;
    logic            EnableChange, DiagonalDoneX, DiagonalDoneY;
    logic            busy, done, found_x, found_y;
    logic [15:0]     TargetX, TargetY;

    always #5 clock = ~clock;

    diag_fetch_ctrl #(.NUM_ROWS(N), .ROW_W(RW)) dut (
        .clock(clock), .reset(reset), .start(start), .X(X), .Y(Y),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .NewRowX(NewRowX), .NewRowY(NewRowY), .Row_noX(Row_noX), .Row_noY(Row_noY),
        .EnableChange(EnableChange), .DiagonalDoneX(DiagonalDoneX),
        .DiagonalDoneY(DiagonalDoneY), .busy(busy), .done(done),
        .found_x(found_x), .found_y(found_y), .TargetX(TargetX), .TargetY(TargetY)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { int addr; bit ch; } req_t;
    typedef struct { int addr; bit ch; logic [255:0] data; } pres_t;

    req_t         eq[$];
    pres_t        pq[$];
    logic [255:0] mem [N];
    int           gnt_dly = 0;
    int           rv_lat  = 1;
    int           ec_cnt, done_cnt, rd_cnt;

    function automatic bit row_hits(input logic [255:0] row, input logic [15:0] t);
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_hits(row[i*16 +: 16], t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Behavioural update unit: sticky match flag, cleared by EnableChange
    logic dx, dy;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dx <= 1'b0;
            dy <= 1'b0;
        end else if (EnableChange) begin
            dx <= 1'b0;
            dy <= 1'b0;
        end else begin
            if (NewRowX != '0 && row_hits(NewRowX, TargetX)) dx <= 1'b1;
            if (NewRowY != '0 && row_hits(NewRowY, TargetY)) dy <= 1'b1;
        end
    end
    assign DiagonalDoneX = dx;
    assign DiagonalDoneY = dy;

    // Reference search: queues the expected read order and returns the found flags
    task automatic predict(input logic [15:0] x, input logic [15:0] y,
                           output bit fx, output bit fy);
        int          cnt [2];
        bit          act [2];
        bit          fnd [2];
        logic [15:0] tgt [2];
        bit          ptr, c;
        cnt[0] = 0; cnt[1] = 0; act[0] = 1; act[1] = 1; fnd[0] = 0; fnd[1] = 0;
        tgt[0] = x; tgt[1] = y; ptr = 0;
        while (act[0] || act[1]) begin
            c   = (act[0] && act[1]) ? ptr : act[1];
            ptr = ~c;
            eq.push_back('{cnt[c], c});
            if (row_hits(mem[cnt[c]], tgt[c])) begin
                act[c] = 0;
                fnd[c] = 1;
            end else if (cnt[c] == N - 1) begin
                act[c] = 0;
            end else begin
                cnt[c]++;
            end
        end
        fx = fnd[0];
        fy = fnd[1];
    endtask

    // Memory responder
    initial begin
        req_t  e;
        pres_t p;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            if (mem_req === 1'b1 && !reset) begin
                rd_cnt++;
                if (eq.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                    e = '{0, 1'b0};
                end else begin
                    e = eq.pop_front();
                end
                chk("mem_addr", mem_addr, e.addr);
                for (int k = 0; k < gnt_dly; k++) begin
                    @(posedge clock); #1;
                    chk("req_hold", {mem_req, mem_addr}, {1'b1, RW'(e.addr)});
                end
                mem_gnt = 1'b1;
                p = '{e.addr, e.ch, mem[e.addr]};
                pq.push_back(p);
                @(posedge clock); #1;
                mem_gnt = 1'b0;
                for (int k = 1; k < rv_lat; k++) begin
                    @(posedge clock); #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = p.data;
                @(posedge clock); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    // Output monitor
    always @(negedge clock) begin
        pres_t p;
        if (!reset) begin
            if (EnableChange) ec_cnt++;
            if (done) done_cnt++;
            if (NewRowX != '0 || NewRowY != '0) begin
                if (NewRowX != '0 && NewRowY != '0) chk("newrow_both", 1, 0);
                if (pq.size() == 0) begin
                    chk("newrow_extra", NewRowX | NewRowY, 0);
                end else begin
                    p = pq.pop_front();
                    chk("newrow_ch", NewRowY != '0, p.ch);
                    chk("newrow_data", p.ch ? NewRowY : NewRowX, p.data);
                    chk("row_no", p.ch ? Row_noY : Row_noX, p.addr);
                end
            end
        end
    end

    task automatic fill();
        for (int r = 0; r < N; r++) begin
            for (int s = 0; s < ENTRIES; s++) begin
                mem[r][s*16 +: 16] = {3'b000, 3'(r), 10'(s + 1 + 16 * r)};
            end
        end
    endtask

    task automatic run_search(input logic [15:0] x, input logic [15:0] y,
                              input int gd, input int lat, input bit intrude,
                              input int exp_reads);
        bit fx, fy;
        int t;
        gnt_dly = gd;
        rv_lat  = lat;
        predict(x, y, fx, fy);
        ec_cnt = 0; done_cnt = 0; rd_cnt = 0;
        X = x; Y = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("ec_after_start", EnableChange, 1);
        chk("busy_run", busy, 1);
        chk("found_clr", {found_x, found_y}, 0);
        chk("target", {TargetX, TargetY}, {x, y});
        @(posedge clock); #1;
        chk("ec_one_cycle", EnableChange, 0);
        if (intrude) begin
            X = ~x; Y = ~y; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(posedge clock); #1;
            t++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("done_once", done_cnt, 1);
        chk("ec_once", ec_cnt, 1);
        chk("found", {found_x, found_y}, {fx, fy});
        chk("busy_idle", busy, 0);
        chk("target_held", {TargetX, TargetY}, {x, y});
        chk("queues_drained", eq.size() + pq.size(), 0);
        if (exp_reads > 0) chk("reads", rd_cnt, exp_reads);
    endtask

    initial begin
        int t;
        bit fx, fy;
        reset = 1'b1; start = 1'b0; X = '0; Y = '0;
        fill();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ctrl", {mem_req, mem_addr, EnableChange, busy, done, found_x, found_y}, 0);
        chk("rst_newrow", NewRowX | NewRowY, 0);
        chk("rst_rowno", {Row_noX, Row_noY}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // X hit on row 2 slot 1, Y hit on row 0 slot 3
        fill();
        mem[2][31:16] = 16'hE005;
        mem[0][63:48] = 16'hE009;
        run_search(16'd5, 16'd9, 0, 1, 1'b0, 4);

        // No match anywhere
        fill();
        run_search(16'd5, 16'd9, 0, 1, 1'b0, 8);

        // Slow grant and longer read latency
        fill();
        mem[3][15:0]    = 16'hE007;
        mem[1][255:240] = 16'hE009;
        run_search(16'd7, 16'd9, 5, 3, 1'b0, 6);

        // Start while busy is ignored
        fill();
        mem[1][47:32] = 16'hE005;
        run_search(16'd5, 16'd9, 0, 2, 1'b1, 6);

        // Back-to-back searches
        fill();
        mem[2][31:16] = 16'hE005;
        mem[0][63:48] = 16'hE009;
        run_search(16'd5, 16'd9, 0, 1, 1'b0, 4);
        run_search(16'd5, 16'd9, 0, 1, 1'b0, 4);

        // Reset while waiting on read data
        fill();
        mem[3][15:0] = 16'hE005;
        gnt_dly = 0; rv_lat = 2;
        predict(16'd5, 16'd9, fx, fy);
        done_cnt = 0;
        X = 16'd5; Y = 16'd9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        t = 0;
        do begin
            @(posedge clock); #3;
            t++;
        end while (mem_gnt !== 1'b1 && t < 100);
        if (mem_gnt !== 1'b1) chk("gnt_timeout", 0, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        eq.delete();
        pq.delete();
        #1;
        chk("rstw_ctrl", {mem_req, mem_addr, EnableChange, busy, done, found_x, found_y}, 0);
        chk("rstw_newrow", NewRowX | NewRowY, 0);
        chk("rstw_rowno", {Row_noX, Row_noY}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("post_rst_busy", {busy, mem_req}, 0);
        chk("post_rst_newrow", NewRowX | NewRowY, 0);
        chk("post_rst_rowno", {Row_noX, Row_noY}, 0);
        chk("post_rst_done", done_cnt, 0);
        repeat (4) @(posedge clock);
        #1;
        eq.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
